// File: rtl/fp16_to_fp8_packer.sv
// Four-lane FP16 -> FP8 (E4M3 / E5M2) converter with round-to-nearest-even.
// Two-stage valid/ready pipeline (unpack/align, round/pack) plus an overflow-lane counter.
module fp16_to_fp8_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        e5m2mode,
  input  logic        sat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_flags,
  input  logic        clr_stats,
  output logic [15:0] ovf_count
);
  localparam int unsigned LANES = 4;

  // Aligned lane: kept magnitude bits, guard/sticky, and the exponent base they sit on
  typedef struct packed {
    logic       sign;
    logic       nan;
    logic       inf;
    logic       zero;
    logic [4:0] ebase;
    logic [3:0] kept;
    logic       guard;
    logic       sticky;
  } lane_t;

  // Normalise the FP16 value, then shift its significand to the FP8 mantissa grid.
  // Results below min normal get extra right shift, which yields the subnormal encoding.
  function automatic lane_t unpack_lane(input logic [15:0] h, input logic e5);
    lane_t       r;
    logic [4:0]  ef;
    logic [9:0]  mf;
    logic [10:0] sig;
    logic [15:0] wide;
    int          ex;
    int          te;
    int          sh;
    r      = '0;
    ef     = h[14:10];
    mf     = h[9:0];
    r.sign = h[15];
    sig    = {1'b1, mf};
    ex     = int'(ef) - 15;
    if (ef == 5'd31) begin
      r.nan = (mf != 10'd0);
      r.inf = (mf == 10'd0);
    end else if (ef == 5'd0) begin
      if (mf == 10'd0) begin
        r.zero = 1'b1;
      end else begin
        sig = '0;
        ex  = 0;
        for (int p = 0; p < 10; p++) begin
          if (mf[p]) begin
            sig = 11'(mf) << (10 - p);
            ex  = p - 24;
          end
        end
      end
    end
    if (!r.nan && !r.inf && !r.zero) begin
      te = ex + (e5 ? 15 : 7);
      sh = (e5 ? 8 : 7) + ((te < 1) ? (1 - te) : 0);
      if (sh > 12) sh = 12;
      wide     = 16'({sig, 12'd0} >> sh);
      r.kept   = wide[15:12];
      r.guard  = wide[11];
      r.sticky = |wide[10:0];
      r.ebase  = (te > 1) ? 5'(te - 1) : 5'd0;
    end
    return r;
  endfunction

  // Round and pack; returns {byte, nan, overflow, underflow, inexact}.
  // Mantissa carry ripples into the exponent field by plain addition.
  function automatic logic [11:0] pack_lane(input lane_t l, input logic e5, input logic st);
    logic [8:0] code;
    logic [6:0] maxc;
    logic       rup;
    logic       ovf;
    logic       unf;
    logic       inx;
    logic [7:0] b;
    maxc = e5 ? 7'h7B : 7'h7E;
    rup  = l.guard & (l.sticky | l.kept[0]);
    code = (e5 ? (9'(l.ebase) << 2) : (9'(l.ebase) << 3)) + 9'(l.kept) + 9'(rup);
    ovf  = l.inf | (!l.nan && (code > 9'(maxc)));
    unf  = !l.nan && !l.inf && !l.zero && (code == 9'd0);
    inx  = !l.nan && (ovf | unf | l.guard | l.sticky);
    if (l.nan)     b = {l.sign, 7'h7F};
    else if (ovf)  b = {l.sign, st ? maxc : (e5 ? 7'h7C : 7'h7F)};
    else           b = {l.sign, code[6:0]};
    return {b, l.nan, ovf, unf, inx};
  endfunction

  logic                   s1_valid;
  lane_t [LANES-1:0]      s1_lane;
  logic                   s1_e5;
  logic                   s1_sat;
  logic [2:0]             s2_novf;
  logic                   s1_adv;
  logic                   s2_adv;
  lane_t [LANES-1:0]      up_lane;
  logic [LANES-1:0][11:0] pk_res;
  logic [31:0]            pk_data;
  logic [3:0]             pk_flags;
  logic [2:0]             pk_novf;
  logic [16:0]            ovf_sum;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign ovf_sum  = 17'(ovf_count) + 17'(s2_novf);

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      up_lane[i] = unpack_lane(in_data[16*i +: 16], e5m2mode);
      pk_res[i]  = pack_lane(s1_lane[i], s1_e5, s1_sat);
    end
  end

  // Merge lane results into the output beat
  always_comb begin
    pk_data  = '0;
    pk_flags = '0;
    pk_novf  = '0;
    for (int i = 0; i < LANES; i++) begin
      pk_data[8*i +: 8] = pk_res[i][11:4];
      pk_flags          = pk_flags | pk_res[i][3:0];
      pk_novf           = pk_novf + 3'(pk_res[i][2]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_lane   <= '0;
      s1_e5     <= 1'b0;
      s1_sat    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
      s2_novf   <= '0;
      ovf_count <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_lane <= up_lane;
          s1_e5   <= e5m2mode;
          s1_sat  <= sat;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data  <= pk_data;
          out_flags <= pk_flags;
          s2_novf   <= pk_novf;
        end
      end
      if (clr_stats)
        ovf_count <= '0;
      else if (out_valid && out_ready)
        ovf_count <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end
  end
endmodule

// File: tb/tb_fp16_to_fp8_packer.sv
// Directed bench for fp16_to_fp8_packer: hand-computed conversions, handshake,
// counter saturation/clear priority and mid-flight reset.
module tb_fp16_to_fp8_packer;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        e5m2mode;
  logic        sat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic        clr_stats;
  logic [15:0] ovf_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] vd   [9];
  logic        vm   [9];
  logic        vs   [9];
  logic [31:0] vexp [9];
  logic [3:0]  vflg [9];
  logic [15:0] vcnt [9];

  fp16_to_fp8_packer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .e5m2mode(e5m2mode), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags),
    .clr_stats(clr_stats), .ovf_count(ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Send one beat into an empty pipeline and collect its result
  task automatic beat(input logic [63:0] d, input logic m, input logic s,
                      output logic [31:0] od, output logic [3:0] of);
    int lat;
    in_data = d; e5m2mode = m; sat = s; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd2);
    od = out_data;
    of = out_flags;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] od;
    logic [3:0]  of;
    logic [31:0] held;
    logic        stalled;
    logic        acc;
    logic        seen;
    int          sent;
    int          rcv;
    int          n;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; e5m2mode = 1'b0; sat = 1'b0;
    out_ready = 1'b1; clr_stats = 1'b0;

    vd[0] = 64'hC600_4200_C480_3E00; vm[0] = 0; vs[0] = 0; vexp[0] = 32'hCC44C93C; vflg[0] = 4'h0; vcnt[0] = 16'd0;
    vd[1] = 64'h5F00_3C00_3CC0_3C40; vm[1] = 0; vs[1] = 0; vexp[1] = 32'h7E383A38; vflg[1] = 4'h1; vcnt[1] = 16'd0;
    vd[2] = 64'h0000_7C00_E3D0_63D0; vm[2] = 0; vs[2] = 1; vexp[2] = 32'h007EFE7E; vflg[2] = 4'h5; vcnt[2] = 16'd3;
    vd[3] = 64'h0000_7C00_E3D0_63D0; vm[3] = 0; vs[3] = 0; vexp[3] = 32'h007FFF7F; vflg[3] = 4'h5; vcnt[3] = 16'd6;
    vd[4] = 64'hFE00_3E00_FBFF_7BFF; vm[4] = 1; vs[4] = 0; vexp[4] = 32'hFF3EFC7C; vflg[4] = 4'hD; vcnt[4] = 16'd8;
    vd[5] = 64'hFE00_3E00_FBFF_7BFF; vm[5] = 1; vs[5] = 1; vexp[5] = 32'hFF3EFB7B; vflg[5] = 4'hD; vcnt[5] = 16'd10;
    vd[6] = 64'h8001_7E00_0001_0000; vm[6] = 0; vs[6] = 0; vexp[6] = 32'h807F0000; vflg[6] = 4'hB; vcnt[6] = 16'd10;
    vd[7] = 64'hFE00_1A00_1400_1800; vm[7] = 0; vs[7] = 0; vexp[7] = 32'hFF020001; vflg[7] = 4'hB; vcnt[7] = 16'd10;
    vd[8] = 64'h0000_0000_8200_0200; vm[8] = 1; vs[8] = 0; vexp[8] = 32'h00008202; vflg[8] = 4'h0; vcnt[8] = 16'd10;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_ovf_count", 64'(ovf_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed conversions, one beat at a time
    for (int i = 0; i < 9; i++) begin
      beat(vd[i], vm[i], vs[i], od, of);
      check($sformatf("data%0d", i),  64'(od),        64'(vexp[i]));
      check($sformatf("flags%0d", i), 64'(of),        64'(vflg[i]));
      check($sformatf("count%0d", i), 64'(ovf_count), 64'(vcnt[i]));
    end

    // Backpressure: 8 beats, random out_ready, mode/sat changing per beat
    sent = 0; rcv = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 300 && rcv < 8; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 1) == 1);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_data = vd[sent]; e5m2mode = vm[sent]; sat = vs[sent];
      end
      #1;
      if (stalled) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data",  64'(out_data),  64'(held));
      end
      check("bp_in_ready", 64'(in_ready), 64'(!((sent - rcv == 2) && !out_ready)));
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check($sformatf("bp_data%0d", rcv),  64'(out_data),  64'(vexp[rcv]));
        check($sformatf("bp_flags%0d", rcv), 64'(out_flags), 64'(vflg[rcv]));
        rcv++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (acc) sent++;
    end
    check("bp_received", 64'(rcv), 64'd8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_drained", 64'(out_valid), 64'd0);
    check("pre_clr_count", 64'(ovf_count), 64'd20);

    // clr_stats wins over an overflowing beat leaving in the same cycle
    out_ready = 1'b0; in_data = vd[2]; e5m2mode = vm[2]; sat = vs[2]; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("clr_wait_valid", 64'(out_valid), 64'd1);
    clr_stats = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    check("clr_priority", 64'(ovf_count), 64'd0);
    check("clr_drained",  64'(out_valid), 64'd0);

    // Counter saturation: 16400 beats of four overflowing lanes
    in_data = {4{16'h63D0}}; e5m2mode = 1'b0; sat = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (16400) @(negedge clk);
    in_valid = 1'b0;
    check("stream_data", 64'(out_data), 64'h7E7E7E7E);
    repeat (4) @(negedge clk);
    check("ovf_saturate", 64'(ovf_count), 64'hFFFF);

    // Reset with two beats in flight
    out_ready = 1'b0; in_data = vd[0]; e5m2mode = 1'b0; sat = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_data = vd[1];
    @(negedge clk);
    in_valid = 1'b0;
    check("inflight_valid", 64'(out_valid), 64'd1);
    check("inflight_full_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_ovf_count", 64'(ovf_count), 64'd0);
    check("midrst_out_data",  64'(out_data),  64'd0);
    rst = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_stale_beat", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp16_to_fp8_packer.md
FP16_TO_FP8_PACKER -- requirements
Module: fp16_to_fp8_packer

Interface
REQ-001 SHALL have one clock and one reset: clk; rst is synchronous, active-high.
REQ-002 Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  64  four IEEE FP16 lanes (1/5/10, bias 15); lane i = in_data[16i+15:16i]
- e5m2mode  in  1  0 = E4M3 (bias 7), 1 = E5M2 (bias 15); sampled with the beat
- sat  in  1  1 = saturate overflow to max finite; sampled with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  32  four FP8 lanes; lane i = out_data[8i+7:8i]
- out_flags  out  4  {nan, overflow, underflow, inexact}, each OR over lanes
- clr_stats  in  1  clears ovf_count
- ovf_count  out  16  saturating count of overflowed lanes

Function
REQ-003 SHALL convert each FP16 lane to FP8 with round-to-nearest-even on magnitude; sign copied.
REQ-004 E4M3 format SHALL be: S.EEEE.MMM, bias 7, no infinities, S.1111.111 = NaN, max finite 448 (0x7E).
REQ-005 E5M2 format SHALL be: S.EEEEE.MM, bias 15, inf = S.11111.00, NaN = S.11111.11 (0x7F/0xFF), max finite 57344 (0x7B).
REQ-006 Overflow (post-rounding magnitude above max finite, or FP16 inf): sat=1 -> signed max finite; sat=0 -> E4M3 signed NaN, E5M2 signed inf; overflow flag set; FP16 inf with sat=0 in E4M3 -> NaN.
REQ-007 FP16 NaN SHALL map to FP8 NaN with input sign regardless of sat; nan flag set; not counted as overflow.
REQ-008 Results below min normal SHALL be FP8 subnormals with RNE; results rounding to zero from nonzero input SHALL yield signed zero and set underflow; FP16 subnormal inputs handled exactly as values.
REQ-009 inexact SHALL set when any lane's discarded bits are nonzero or overflow/underflow occurs.
REQ-010 Pipeline SHALL be two registered stages (S1 unpack/align, S2 round/pack); out_data/out_flags driven from S2 registers.
REQ-011 Latency: beat accepted at edge N with no stall appears with out_valid=1 after edge N+2.
REQ-012 Handshake: transfer on in_valid&&in_ready (input) and out_valid&&out_ready (output); S2 advances when !S2_valid || out_ready; S1 advances when !S1_valid || S2 advances; in_ready = !S1_valid || S2 advances (combinational, no dependence on in_valid).
REQ-013 Under out_ready=0, out_data/out_flags/out_valid SHALL hold stable; two beats buffered max; no beat lost or duplicated; order preserved.
REQ-014 e5m2mode and sat SHALL travel with their beat; changing them mid-stream affects only later-accepted beats.
REQ-015 ovf_count SHALL add the number of overflowed lanes (0-4) when a beat leaves S2 (output handshake), saturating at 0xFFFF; clr_stats has priority over increment in the same cycle (count = 0).

Reset
REQ-016 On rst: S1/S2 valid = 0, out_valid=0, out_data=0, out_flags=0, ovf_count=0; in_ready=1 in the first cycle after rst deasserts.
REQ-017 rst mid-operation SHALL discard all in-flight beats; none emitted after reset.

Verification
REQ-018 E4M3, sat=0: in_data=0xC600_4200_C480_3E00 (-6,3,-4.5,1.5) -> out_data=0xCC44C93C, flags=0, two cycles after accept.
REQ-019 RNE ties, E4M3: lanes 0x3C40 (1.0625) -> 0x38, 0x3CC0 (1.1875) -> 0x3A; inexact=1.
REQ-020 Overflow: 0x63D0 (1000.0) E4M3 sat=1 -> 0x7E, sat=0 -> 0x7F; E5M2 0x7BFF sat=0 -> 0x7C, sat=1 -> 0x7B; overflow=1; ovf_count increments per lane.
REQ-021 E5M2 0x3E00 -> 0x3E exact; FP16 NaN 0xFE00 -> 0xFF both modes, nan=1; 0x0001 -> 0x00 (E4M3), underflow=1.
REQ-022 Backpressure: stream 8 beats with out_ready toggling randomly -> all 8 outputs in order, held stable while stalled, in_ready=0 when both stages full and out_ready=0.
REQ-023 Assert rst with two beats in flight -> out_valid=0 next cycle, ovf_count=0, no stale beat emitted afterward.
